// File: rtl/traffic_light_controller.sv
// Two-road intersection controller: synchronizes the divided tick, pedestrian and night inputs,
// sequences green/yellow/all-red phases with a per-phase countdown, and drives lamps plus BCD digits.
module traffic_light_controller #(
   parameter int unsigned GREEN_S  = 15,
   parameter int unsigned YELLOW_S = 3,
   parameter int unsigned ALLRED_S = 1,
   parameter int unsigned PED_CUT  = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       ped_req,
   input  logic       night,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       ped_walk,
   output logic [3:0] count_tens,
   output logic [3:0] count_ones
);

   localparam int unsigned CW = 7;
   localparam logic [CW-1:0] GREEN_C  = CW'(GREEN_S);
   localparam logic [CW-1:0] YELLOW_C = CW'(YELLOW_S);
   localparam logic [CW-1:0] ALLRED_C = CW'(ALLRED_S);
   localparam logic [CW-1:0] CUT_C    = CW'(PED_CUT);
   localparam logic [CW-1:0] TEN_C    = CW'(10);

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_OFF    = 3'b000;

   typedef enum logic [2:0] {
      NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, FLASH
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic            ped_pending, pend_next;
   logic            flash_phase, fph_next;
   logic [2:0]      tick_sync, ped_sync;
   logic [1:0]      night_sync;
   logic            tick, ped_edge, night_s;
   logic [2:0]      ns_next, ew_next;
   logic            walk_next;
   logic [3:0]      tens_next, ones_next;

   assign tick     = tick_sync[1] & ~tick_sync[2];
   assign ped_edge = ped_sync[1] & ~ped_sync[2];
   assign night_s  = night_sync[1];

   // Synchronizers; bit 0 is the first flop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_sync  <= '0;
         ped_sync   <= '0;
         night_sync <= '0;
      end else begin
         tick_sync  <= {tick_sync[1:0], tick_in};
         ped_sync   <= {ped_sync[1:0], ped_req};
         night_sync <= {night_sync[0], night};
      end
   end

   // State, counter, flags and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= NS_GREEN;
         cnt         <= GREEN_C;
         ped_pending <= 1'b0;
         flash_phase <= 1'b0;
         ns_light    <= LAMP_GREEN;
         ew_light    <= LAMP_RED;
         ped_walk    <= 1'b1;
         count_tens  <= 4'(GREEN_C / TEN_C);
         count_ones  <= 4'(GREEN_C % TEN_C);
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         ped_pending <= pend_next;
         flash_phase <= fph_next;
         ns_light    <= ns_next;
         ew_light    <= ew_next;
         ped_walk    <= walk_next;
         count_tens  <= tens_next;
         count_ones  <= ones_next;
      end
   end

   // Next-state, countdown and output decode
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pend_next  = ped_pending;
      fph_next   = flash_phase;
      ns_next    = LAMP_RED;
      ew_next    = LAMP_RED;
      walk_next  = 1'b0;
      tens_next  = 4'd0;
      ones_next  = 4'd0;

      if (tick) begin
         if (night_s && state != FLASH) begin
            state_next = FLASH;
            fph_next   = 1'b1;
            cnt_next   = '0;
         end else if (state == FLASH) begin
            if (night_s) begin
               fph_next = ~flash_phase;
            end else begin
               state_next = ALLRED_B;
               cnt_next   = ALLRED_C;
            end
         end else if (cnt == CW'(1)) begin
            unique case (state)
               NS_GREEN:  begin state_next = NS_YELLOW; cnt_next = YELLOW_C; end
               NS_YELLOW: begin state_next = ALLRED_A;  cnt_next = ALLRED_C; end
               ALLRED_A:  begin state_next = EW_GREEN;  cnt_next = GREEN_C;  end
               EW_GREEN:  begin state_next = EW_YELLOW; cnt_next = YELLOW_C; end
               EW_YELLOW: begin state_next = ALLRED_B;  cnt_next = ALLRED_C; end
               default:   begin state_next = NS_GREEN;  cnt_next = GREEN_C;  end
            endcase
         end else if (state == EW_GREEN && ped_pending && cnt > CUT_C) begin
            cnt_next = CUT_C;
         end else begin
            cnt_next = cnt - CW'(1);
         end
      end

      // Clearing on NS_GREEN/FLASH entry takes precedence over a new request
      if ((state_next == NS_GREEN && state != NS_GREEN) ||
          (state_next == FLASH && state != FLASH)) begin
         pend_next = 1'b0;
      end else if (ped_edge && state != FLASH) begin
         pend_next = 1'b1;
      end

      unique case (state_next)
         NS_GREEN:  begin ns_next = LAMP_GREEN;  walk_next = 1'b1; end
         NS_YELLOW: ns_next = LAMP_YELLOW;
         EW_GREEN:  ew_next = LAMP_GREEN;
         EW_YELLOW: ew_next = LAMP_YELLOW;
         FLASH: begin
            ns_next = fph_next ? LAMP_YELLOW : LAMP_OFF;
            ew_next = fph_next ? LAMP_RED : LAMP_OFF;
         end
         default: ;
      endcase

      if (state_next != FLASH) begin
         tens_next = 4'(cnt_next / TEN_C);
         ones_next = 4'(cnt_next % TEN_C);
      end
   end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: phase-table model checked every cycle, plus directed literal checks.
module tb_traffic_light_controller;

   localparam int GREEN_S  = 15;
   localparam int YELLOW_S = 3;
   localparam int ALLRED_S = 1;
   localparam int PED_CUT  = 5;
   localparam int FLASH_PH = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_in = 1'b0;
   logic       ped_req = 1'b0;
   logic       night = 1'b0;
   logic [2:0] ns_light, ew_light;
   logic       ped_walk;
   logic [3:0] count_tens, count_ones;

   int vectors = 0;
   int miscompares = 0;

   traffic_light_controller dut (
      .clk(clk), .reset(reset), .tick_in(tick_in), .ped_req(ped_req), .night(night),
      .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
      .count_tens(count_tens), .count_ones(count_ones)
   );

   always #5 clk = ~clk;

   // Phase order: NS green, NS yellow, all-red, EW green, EW yellow, all-red
   int         dur    [6] = '{GREEN_S, YELLOW_S, ALLRED_S, GREEN_S, YELLOW_S, ALLRED_S};
   logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

   int         m_phase = 0;
   int         m_rem   = GREEN_S;
   logic       m_pend  = 1'b0;
   logic       m_fph   = 1'b0;
   // Input sample histories, newest in bit 0
   logic [3:0] th = '0, ph = '0, nh = '0;

   always @(posedge clk or negedge reset) begin : model
      int   np, nr, old;
      logic nf, npd, tk, pe, ns;
      if (!reset) begin
         m_phase <= 0; m_rem <= GREEN_S; m_pend <= 1'b0; m_fph <= 1'b0;
         th <= '0; ph <= '0; nh <= '0;
      end else begin
         tk = th[1] & ~th[2];
         pe = ph[1] & ~ph[2];
         ns = nh[1];
         np = m_phase; nr = m_rem; nf = m_fph; npd = m_pend; old = m_phase;
         if (tk) begin
            if (ns && old != FLASH_PH) begin
               np = FLASH_PH; nf = 1'b1; nr = 0;
            end else if (old == FLASH_PH) begin
               if (ns) nf = ~m_fph;
               else begin np = 5; nr = ALLRED_S; end
            end else if (m_rem == 1) begin
               np = (old + 1) % 6; nr = dur[np];
            end else if (old == 3 && m_pend && m_rem > PED_CUT) begin
               nr = PED_CUT;
            end else begin
               nr = m_rem - 1;
            end
         end
         if ((np == 0 && old != 0) || (np == FLASH_PH && old != FLASH_PH)) npd = 1'b0;
         else if (pe && old != FLASH_PH) npd = 1'b1;
         m_phase <= np; m_rem <= nr; m_fph <= nf; m_pend <= npd;
         th <= {th[2:0], tick_in};
         ph <= {ph[2:0], ped_req};
         nh <= {nh[2:0], night};
      end
   end

   function automatic void check(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endfunction

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (reset) begin
         logic [2:0] ens, eew;
         if (m_phase == FLASH_PH) begin
            ens = m_fph ? 3'b010 : 3'b000;
            eew = m_fph ? 3'b100 : 3'b000;
         end else begin
            ens = ns_tab[m_phase];
            eew = ew_tab[m_phase];
         end
         check("model_ns", int'(ns_light), int'(ens));
         check("model_ew", int'(ew_light), int'(eew));
         check("model_walk", int'(ped_walk), (m_phase == 0) ? 1 : 0);
         check("model_tens", int'(count_tens), (m_phase == FLASH_PH) ? 0 : m_rem / 10);
         check("model_ones", int'(count_ones), (m_phase == FLASH_PH) ? 0 : m_rem % 10);
      end
   end

   task automatic do_tick();
      @(negedge clk); tick_in = 1'b1;
      repeat (3) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic lit(string name, int ns, int ew, int walk, int tens, int ones);
      check({name, "_ns"}, int'(ns_light), ns);
      check({name, "_ew"}, int'(ew_light), ew);
      check({name, "_walk"}, int'(ped_walk), walk);
      check({name, "_tens"}, int'(count_tens), tens);
      check({name, "_ones"}, int'(count_ones), ones);
   endtask

   initial begin
      #1 reset = 1'b0;
      #3 lit("reset", 3'b001, 3'b100, 1, 1, 5);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);

      ticks(15);
      lit("ns_yellow", 3'b010, 3'b100, 0, 0, 3);
      ticks(23);
      lit("full_cycle", 3'b001, 3'b100, 1, 1, 5);

      // Pedestrian request while EW green at 12
      ticks(22);
      lit("ew_green12", 3'b100, 3'b001, 0, 1, 2);
      @(negedge clk); ped_req = 1'b1;
      repeat (2) @(negedge clk); ped_req = 1'b0;
      repeat (4) @(negedge clk);
      do_tick();
      lit("ped_cut", 3'b100, 3'b001, 0, 0, 5);
      ticks(4);
      lit("ped_cut_last", 3'b100, 3'b001, 0, 0, 1);
      do_tick();
      lit("ped_ew_yellow", 3'b100, 3'b010, 0, 0, 3);
      ticks(4);
      lit("ped_ns_green", 3'b001, 3'b100, 1, 1, 5);

      // Pedestrian edge coincident with a tick
      ticks(22);
      @(negedge clk); tick_in = 1'b1; ped_req = 1'b1;
      repeat (3) @(negedge clk);
      tick_in = 1'b0; ped_req = 1'b0;
      repeat (3) @(negedge clk);
      lit("coinc_first", 3'b100, 3'b001, 0, 1, 1);
      do_tick();
      lit("coinc_cut", 3'b100, 3'b001, 0, 0, 5);
      ticks(9);
      lit("coinc_back", 3'b001, 3'b100, 1, 1, 5);

      // Night flashing entry and exit
      ticks(6);
      lit("pre_night", 3'b001, 3'b100, 1, 0, 9);
      @(negedge clk); night = 1'b1;
      repeat (4) @(negedge clk);
      lit("night_no_tick", 3'b001, 3'b100, 1, 0, 9);
      do_tick();
      lit("flash_on", 3'b010, 3'b100, 0, 0, 0);
      do_tick();
      lit("flash_off", 3'b000, 3'b000, 0, 0, 0);
      @(negedge clk); night = 1'b0;
      repeat (4) @(negedge clk);
      do_tick();
      lit("night_exit", 3'b100, 3'b100, 0, 0, 1);
      do_tick();
      lit("night_ns_green", 3'b001, 3'b100, 1, 1, 5);

      // Long-held and single-cycle tick_in
      @(negedge clk); tick_in = 1'b1;
      repeat (1000) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      lit("held_high", 3'b001, 3'b100, 1, 1, 4);
      @(negedge clk); tick_in = 1'b1;
      @(negedge clk); tick_in = 1'b0;
      repeat (3) @(negedge clk);
      lit("one_clk", 3'b001, 3'b100, 1, 1, 3);

      // Asynchronous reset in the middle of EW yellow
      ticks(13 + 4 + 15 + 1);
      lit("ew_yellow", 3'b100, 3'b010, 0, 0, 2);
      @(negedge clk); #2 reset = 1'b0;
      #1 lit("async_reset", 3'b001, 3'b100, 1, 1, 5);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      do_tick();
      lit("post_reset", 3'b001, 3'b100, 1, 1, 4);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
